miyamii_ram_unit: RTL and testbench

- Data-RAM subsystem directly downstream of the miyamii_4000 core's RAM interface.
- Consumes the core's ram_addr / ram_data_out / ram_we / ram_ce and returns read nibbles on ram_data_in.
- Also latches the core's RAM output port onto external pins.
- Contains a post-reset clear engine so RAM contents are deterministic before the program runs.

---
 rtl/miyamii_pkg.sv | 17 +
 rtl/miyamii_ram_array.sv | 32 +++
 rtl/miyamii_ram_unit.sv | 156 +++++++++++++++
 tb/tb_miyamii_ram_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miyamii_pkg.sv
// Shared constants, FSM state type and parity helper for the miyamii RAM unit.
package miyamii_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned RAM_DEPTH = 1280;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Even parity bit: stored alongside the nibble so the 5-bit word XORs to 0.
    function automatic logic even_parity(input logic [NIBBLE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/miyamii_ram_array.sv
// Plain synchronous single-port array with registered read (read-before-write).
module miyamii_ram_array
    import miyamii_pkg::*;
#(
    parameter int unsigned DEPTH = RAM_DEPTH,
    parameter int unsigned AW    = $clog2(RAM_DEPTH),
    parameter int unsigned WIDTH = NIBBLE_W
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Enabled access: old contents go to the read register, then the write lands.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/miyamii_ram_unit.sv
// Data-RAM subsystem behind the miyamii_4000 core: post-reset clear engine,
// range-checked core accesses and the output-port latch.
// Optional macro MIYAMII_RAM_PARITY_EN adds a per-location even parity bit
// and drives parity_err; without it parity_err is tied low.
module miyamii_ram_unit
    import miyamii_pkg::*;
#(
    parameter int unsigned        DEPTH      = RAM_DEPTH,
    parameter int unsigned        ADDR_W     = 12,
    parameter int unsigned        DATA_W     = NIBBLE_W,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_we,
    input  logic              ram_ce,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_port_out,
    input  logic              ram_port_we,
    output logic [DATA_W-1:0] port_pins,
    output logic              init_busy,
    output logic              addr_err,
    output logic              parity_err
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef MIYAMII_RAM_PARITY_EN
    localparam int unsigned       MEM_W     = DATA_W + 1;
`else
    localparam int unsigned       MEM_W     = DATA_W;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_zero;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_port;

    logic              w_run;
    logic              w_in_range;
    logic              w_valid;
    logic              w_arr_en;
    logic              w_arr_we;
    logic [IDX_W-1:0]  w_arr_addr;
    logic [MEM_W-1:0]  w_arr_wdata;
    logic [MEM_W-1:0]  w_arr_rdata;
    logic [MEM_W-1:0]  w_init_word;
    logic [MEM_W-1:0]  w_core_word;

    assign w_run      = (r_state == ST_RUN) && !rst;
    assign w_in_range = (ram_addr <= LAST_ADDR);
    assign w_valid    = w_run && ram_ce && w_in_range;

`ifdef MIYAMII_RAM_PARITY_EN
    assign w_init_word = {even_parity(INIT_VALUE), INIT_VALUE};
    assign w_core_word = {even_parity(ram_data_out), ram_data_out};
`else
    assign w_init_word = INIT_VALUE;
    assign w_core_word = ram_data_out;
`endif

    // Array port mux: clear engine owns the array until RUN, then the core.
    always_comb begin
        w_arr_en    = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_addr  = ram_addr[IDX_W-1:0];
        w_arr_wdata = w_core_word;
        if (r_state == ST_CLEAR) begin
            w_arr_en    = 1'b1;
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_cnt[IDX_W-1:0];
            w_arr_wdata = w_init_word;
        end else begin
            w_arr_en = w_valid;
            w_arr_we = w_valid && ram_we;
        end
    end

    miyamii_ram_array #(
        .DEPTH (DEPTH),
        .AW    (IDX_W),
        .WIDTH (MEM_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Clear FSM: walk the counter over every location, then hand over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            if (r_clr_cnt == LAST_ADDR) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Read-output qualifier: r_zero masks the array register after reset,
    // during CLEAR and after an out-of-range access; it holds while ce is low
    // so ram_data_in keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero     <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_run && ram_ce && !w_in_range;
            if (r_state == ST_CLEAR) begin
                r_zero <= 1'b1;
            end else if (ram_ce) begin
                r_zero <= !w_in_range;
            end
        end
    end

    // Output-port latch, independent of the memory path and the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port <= '0;
        end else if (ram_port_we) begin
            r_port <= ram_port_out;
        end
    end

`ifdef MIYAMII_RAM_PARITY_EN
    logic r_rd_chk;

    // Marks the cycle whose ram_data_in came from a valid read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_chk <= 1'b0;
        end else begin
            r_rd_chk <= w_valid;
        end
    end

    assign parity_err = r_rd_chk && (^w_arr_rdata);
`else
    assign parity_err = 1'b0;
`endif

    assign ram_data_in = r_zero ? '0 : w_arr_rdata[DATA_W-1:0];
    assign port_pins   = r_port;
    assign init_busy   = (r_state == ST_CLEAR);
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_miyamii_ram_unit.sv
// Self-checking bench for miyamii_ram_unit: behavioural model plus directed
// literal checks and randomized traffic.
module tb_miyamii_ram_unit;

    localparam int DEPTH = 1280;

    logic        clk;
    logic        rst;
    logic [11:0] ram_addr;
    logic [3:0]  ram_data_out;
    logic        ram_we;
    logic        ram_ce;
    logic [3:0]  ram_data_in;
    logic [3:0]  ram_port_out;
    logic        ram_port_we;
    logic [3:0]  port_pins;
    logic        init_busy;
    logic        addr_err;
    logic        parity_err;

    int total = 0;
    int bad   = 0;

    miyamii_ram_unit #(
        .DEPTH      (1280),
        .ADDR_W     (12),
        .DATA_W     (4),
        .INIT_VALUE (4'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_addr     (ram_addr),
        .ram_data_out (ram_data_out),
        .ram_we       (ram_we),
        .ram_ce       (ram_ce),
        .ram_data_in  (ram_data_in),
        .ram_port_out (ram_port_out),
        .ram_port_we  (ram_port_we),
        .port_pins    (port_pins),
        .init_busy    (init_busy),
        .addr_err     (addr_err),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_mem [DEPTH];
    bit         m_bad [DEPTH];
    int         m_clr;
    bit         m_live = 0;
    logic [3:0] e_data, e_port;
    logic       e_err, e_par, e_busy;

    task automatic model_step();
        int a;
        a = int'(ram_addr);
        if (rst) begin
            e_data = '0; e_port = '0; e_err = 0; e_par = 0; e_busy = 1;
            m_clr = 0; m_live = 1;
        end else if (e_busy) begin
            e_err = 0; e_par = 0; e_data = '0;
            if (ram_port_we) e_port = ram_port_out;
            m_clr++;
            if (m_clr == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i] = 4'h0;
                    m_bad[i] = 0;
                end
                e_busy = 0;
            end
        end else begin
            e_err = ram_ce && (a >= DEPTH);
            e_par = 0;
            if (ram_ce) begin
                if (a < DEPTH) begin
                    e_data = m_mem[a];
`ifdef MIYAMII_RAM_PARITY_EN
                    e_par = m_bad[a];
`endif
                    if (ram_we) begin
                        m_mem[a] = ram_data_out;
                        m_bad[a] = 0;
                    end
                end else begin
                    e_data = '0;
                end
            end
            if (ram_port_we) e_port = ram_port_out;
        end
    endtask

    // Single compare process: model advances on the edge, outputs checked mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_live) begin
                check("m_data", 32'(ram_data_in), 32'(e_data));
                check("m_port", 32'(port_pins),   32'(e_port));
                check("m_busy", 32'(init_busy),   32'(e_busy));
                check("m_aerr", 32'(addr_err),    32'(e_err));
                check("m_perr", 32'(parity_err),  32'(e_par));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit c, input bit w, input logic [11:0] a,
                        input logic [3:0] d, input bit pw, input logic [3:0] pd);
        ram_ce = c; ram_we = w; ram_addr = a; ram_data_out = d;
        ram_port_we = pw; ram_port_out = pd;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 12'h000, 4'h0, 0, 4'h0);
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (init_busy && n < 3000) begin
            idle();
            n++;
        end
        check(nm, 32'(n), 32'd1280);
    endtask

    task automatic read_all_nonzero(input string nm);
        int nz;
        nz = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 12'(i), 4'h0, 0, 4'h0);
            if (ram_data_in !== 4'h0) nz++;
        end
        check(nm, 32'(nz), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1;
        ram_ce = 0; ram_we = 0; ram_addr = '0; ram_data_out = '0;
        ram_port_we = 0; ram_port_out = '0;
        idle(); idle();
        check("rst_busy", 32'(init_busy),   32'd1);
        check("rst_port", 32'(port_pins),   32'd0);
        check("rst_data", 32'(ram_data_in), 32'd0);
        check("rst_aerr", 32'(addr_err),    32'd0);
        rst = 0;

        // Port latch and ignored core accesses during CLEAR
        step(0, 0, 12'h000, 4'h0, 1, 4'h9);
        check("clr_port_latch", 32'(port_pins), 32'h9);
        idle();
        check("clr_port_hold", 32'(port_pins), 32'h9);
        step(1, 1, 12'h500, 4'hF, 0, 4'h0);
        check("clr_no_aerr", 32'(addr_err), 32'd0);
        step(1, 1, 12'h005, 4'hF, 0, 4'h0);
        check("clr_data0", 32'(ram_data_in), 32'd0);
        n = 4;
        while (n < 600) begin idle(); n++; end

        // Reset at clear counter 600 restarts the full sequence
        rst = 1; idle(); rst = 0;
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        wait_clear("clear_len_after_mid_rst");
        read_all_nonzero("clear_contents_1");

        // Preload every location with A, then reset in RUN and re-clear
        for (int i = 0; i < DEPTH; i++) step(1, 1, 12'(i), 4'hA, 0, 4'h0);
        step(1, 0, 12'h123, 4'h0, 0, 4'h0);
        check("preload_A", 32'(ram_data_in), 32'hA);
        step(0, 0, 12'h000, 4'h0, 1, 4'h5);
        check("run_port", 32'(port_pins), 32'h5);
        rst = 1; idle(); rst = 0;
        check("run_rst_port", 32'(port_pins), 32'd0);
        check("run_rst_busy", 32'(init_busy), 32'd1);
        wait_clear("clear_len_after_run_rst");
        read_all_nonzero("clear_contents_2");

        // Write/read and read-before-write at 0x005
        step(1, 1, 12'h005, 4'h7, 0, 4'h0);
        check("wr_old_data", 32'(ram_data_in), 32'h0);
        step(1, 0, 12'h005, 4'h0, 0, 4'h0);
        check("rd_7", 32'(ram_data_in), 32'h7);
        step(1, 1, 12'h005, 4'h3, 0, 4'h0);
        check("rbw_old7", 32'(ram_data_in), 32'h7);
        step(1, 0, 12'h005, 4'h0, 0, 4'h0);
        check("rd_3", 32'(ram_data_in), 32'h3);
        step(0, 0, 12'h000, 4'h0, 0, 4'h0);
        check("ce0_hold", 32'(ram_data_in), 32'h3);

        // Out of range and boundary
        step(1, 1, 12'h500, 4'hF, 0, 4'h0);
        check("oor_wr_aerr", 32'(addr_err),    32'd1);
        check("oor_wr_data", 32'(ram_data_in), 32'd0);
        idle();
        check("oor_pulse_end", 32'(addr_err), 32'd0);
        step(1, 0, 12'h500, 4'h0, 0, 4'h0);
        check("oor_rd_aerr", 32'(addr_err), 32'd1);
        step(1, 0, 12'hFFF, 4'h0, 0, 4'h0);
        check("oor_fff_aerr", 32'(addr_err), 32'd1);
        step(1, 0, 12'h000, 4'h0, 0, 4'h0);
        check("loc0_unchanged", 32'(ram_data_in), 32'h0);
        check("loc0_no_aerr",   32'(addr_err),    32'd0);
        step(1, 1, 12'h4FF, 4'hB, 1, 4'hC);
        check("last_no_aerr", 32'(addr_err),  32'd0);
        check("port_with_mem", 32'(port_pins), 32'hC);
        step(1, 0, 12'h4FF, 4'h0, 0, 4'h0);
        check("last_rd", 32'(ram_data_in), 32'hB);

`ifdef MIYAMII_RAM_PARITY_EN
        step(1, 1, 12'h010, 4'h6, 0, 4'h0);
        idle();
        dut.u_array.r_mem[16][4] = ~dut.u_array.r_mem[16][4];
        m_bad[16] = 1;
        step(1, 0, 12'h010, 4'h0, 0, 4'h0);
        check("par_err", 32'(parity_err),  32'd1);
        check("par_data", 32'(ram_data_in), 32'h6);
        idle();
        check("par_pulse_end", 32'(parity_err), 32'd0);
`else
        step(1, 0, 12'h010, 4'h0, 0, 4'h0);
        check("par_off", 32'(parity_err), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [11:0] a;
            case ($urandom % 8)
                0:       a = 12'($urandom_range(1280, 4095));
                1:       a = ($urandom % 2) ? 12'd1279 : 12'd1280;
                default: a = 12'($urandom_range(0, 31));
            endcase
            step(($urandom % 4) != 0, $urandom % 2, a, 4'($urandom),
                 ($urandom % 4) == 0, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
